// File: rtl/dmem_responder_if.sv
// Memory-stage request/response bundle between the pipeline datapath (master)
// and the data-memory responder (slave).
interface dmem_responder_if;
   logic        MemReadM;
   logic        MemWriteM;
   logic [31:0] AddrM;
   logic [31:0] WriteDataM;
   logic [31:0] ReadDataM;
   logic        StallM;
   logic        MisalignM;

   modport master (
      output MemReadM, MemWriteM, AddrM, WriteDataM,
      input  ReadDataM, StallM, MisalignM
   );

   modport slave (
      input  MemReadM, MemWriteM, AddrM, WriteDataM,
      output ReadDataM, StallM, MisalignM
   );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder with RD_LAT access latency and pipeline stall.
// Define DMEM_WRITE_BUFFER_EN to post aligned stores through a one-entry write buffer.
module dmem_responder #(
   parameter int DEPTH  = 64,
   parameter int RD_LAT = 2
) (
   input logic             clk,
   input logic             reset,
   dmem_responder_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(RD_LAT + 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(RD_LAT - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [31:0]    r_ram [DEPTH];
   logic [1:0]     r_state;
   logic [CW-1:0]  r_cnt;
   logic [AW-1:0]  r_idx;
   logic [31:0]    r_data;
   logic           r_is_store;
   logic [31:0]    r_rdata;

   logic           w_req;
   logic           w_go;
   logic           w_start;
   logic           w_idle_stall;
   logic           w_enter_done;
   logic           w_load_enter;
   logic           w_commit;
   logic           w_we;
   logic [AW-1:0]  w_idx;
   logic [AW-1:0]  w_rd_idx;
   logic [AW-1:0]  w_we_idx;
   logic [31:0]    w_we_data;
   logic           w_unused_addr;

   assign w_req         = bus.MemReadM | bus.MemWriteM;
   assign w_idx         = bus.AddrM[AW+1:2];
   assign w_go          = w_req && (bus.AddrM[1:0] == 2'b00);
   assign bus.MisalignM = w_req && (bus.AddrM[1:0] != 2'b00);
   // Upper address bits alias onto the same words.
   assign w_unused_addr = ^bus.AddrM[31:AW+2];

   assign w_commit = (r_state == S_DONE) && r_is_store;

`ifdef DMEM_WRITE_BUFFER_EN
   logic           r_wb_valid;
   logic [AW-1:0]  r_wb_idx;
   logic [31:0]    r_wb_data;
   logic [CW-1:0]  r_wb_cnt;
   logic           w_wb_capture;
   logic           w_wb_drain;

   assign w_wb_capture = (r_state == S_IDLE) && w_go && bus.MemWriteM && !r_wb_valid;
   assign w_wb_drain   = r_wb_valid && (r_wb_cnt == '0);
   // Only loads take the FSM path; anything arriving behind a pending post waits.
   assign w_start      = (r_state == S_IDLE) && w_go && !bus.MemWriteM && !r_wb_valid;
   assign w_idle_stall = w_go && (r_wb_valid || !bus.MemWriteM);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wb_valid <= 1'b0;
         r_wb_cnt   <= '0;
         r_wb_idx   <= '0;
         r_wb_data  <= '0;
      end else if (w_wb_capture) begin
         r_wb_valid <= 1'b1;
         r_wb_cnt   <= CNT_INIT;
         r_wb_idx   <= w_idx;
         r_wb_data  <= bus.WriteDataM;
      end else if (r_wb_valid) begin
         if (r_wb_cnt == '0)
            r_wb_valid <= 1'b0;
         else
            r_wb_cnt <= r_wb_cnt - CW'(1);
      end
   end

   assign w_we      = w_commit || w_wb_drain;
   assign w_we_idx  = w_commit ? r_idx  : r_wb_idx;
   assign w_we_data = w_commit ? r_data : r_wb_data;
`else
   assign w_start      = (r_state == S_IDLE) && w_go;
   assign w_idle_stall = w_go;

   assign w_we      = w_commit;
   assign w_we_idx  = r_idx;
   assign w_we_data = r_data;
`endif

   assign bus.StallM = (r_state == S_IDLE) ? w_idle_stall : (r_state == S_BUSY);

   // With RD_LAT=1 the IDLE cycle jumps straight to DONE, so the read uses the live address.
   assign w_enter_done = ((r_state == S_BUSY) && (r_cnt == CW'(1))) ||
                         (w_start && (RD_LAT == 1));
   assign w_load_enter = w_enter_done &&
                         ((r_state == S_IDLE) ? !bus.MemWriteM : !r_is_store);
   assign w_rd_idx     = (r_state == S_IDLE) ? w_idx : r_idx;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_idx      <= '0;
         r_data     <= '0;
         r_is_store <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_idx      <= w_idx;
                  r_data     <= bus.WriteDataM;
                  r_is_store <= bus.MemWriteM;
                  r_cnt      <= CNT_INIT;
                  r_state    <= (RD_LAT == 1) ? S_DONE : S_BUSY;
               end
            end
            S_BUSY: begin
               r_cnt <= r_cnt - CW'(1);
               if (r_cnt == CW'(1))
                  r_state <= S_DONE;
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // RAM contents survive reset; a store still in flight at reset is simply never written.
   always_ff @(posedge clk) begin
      if (w_we && !reset)
         r_ram[w_we_idx] <= w_we_data;
   end

   always_ff @(posedge clk) begin
      if (reset)
         r_rdata <= '0;
      else if (w_load_enter)
         r_rdata <= r_ram[w_rd_idx];
   end

   assign bus.ReadDataM = r_rdata;
endmodule
